alu_ctrl: RTL and testbench

Sequencing front-end for the 8-bit ALU datapath: accepts one operation at a time over a valid/ready request channel, runs the selected function, and returns a registered result over a valid/ready response channel. Add, subtract, multiply and compare complete in one execute cycle. Divide is an 8-iteration restoring sequence owned by this block. The block sits between the microprocessor control unit and the ALU components, so the core sees a single uniform handshake for every operation.

---
 rtl/alu_ctrl_if.sv | 26 ++
 rtl/alu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_alu_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Request/response channel between the control unit and the ALU sequencer.
// The master side is the control unit; the slave side is alu_ctrl.
interface alu_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [7:0] rsp_aux;
    logic       rsp_zero;
    logic       rsp_err;
    logic       busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_aux, rsp_zero, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_aux, rsp_zero, rsp_err, busy
    );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencing front-end for the 8-bit ALU datapath.
// One operation at a time: accept on a valid/ready request, execute, then
// hold a registered response until the consumer takes it.
// Optional feature: define ALU_CTRL_DIV_EN to build the 8-iteration restoring
// divider; without it op 100 is reported as illegal.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | ready for a request; latches op/A/B on req_valid
//   S_EXEC | single-cycle ops, illegal op, divide-by-zero; registers result
//   S_DIV  | one restoring-division iteration per cycle (8 total)
//   S_RESP | response held on rsp_*; leaves on rsp_ready
module alu_ctrl (
    input  logic      clk,
    input  logic      clrn,
    alu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_CMP = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [7:0]  a_q, b_q;
    logic [7:0]  res_q, aux_q;
    logic        zero_q, err_q;
    logic        accept, div_start;
    logic [7:0]  ex_res, ex_aux, diff;
    logic        ex_err;
    logic [15:0] prod;

`ifdef ALU_CTRL_DIV_EN
    logic [7:0]  rem_q, quo_q, rem_d, quo_d;
    logic [3:0]  cnt_q;
    logic [8:0]  trial;
    logic        div_last;
`endif

    assign accept = (state_q == S_IDLE) && bus.req_valid;

`ifdef ALU_CTRL_DIV_EN
    // A zero divisor never enters the iterative loop; EXEC reports it directly.
    assign div_start = accept && (bus.req_op == OP_DIV) && (bus.req_b != 8'd0);
    assign div_last  = (cnt_q == 4'd0);
`else
    assign div_start = 1'b0;
`endif

    assign diff = a_q - b_q;
    assign prod = {8'd0, a_q} * {8'd0, b_q};

    assign bus.rsp_result = res_q;
    assign bus.rsp_aux    = aux_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (accept) state_d = div_start ? S_DIV : S_EXEC;
            end
            S_EXEC: state_d = S_RESP;
`ifdef ALU_CTRL_DIV_EN
            S_DIV:  if (div_last) state_d = S_RESP;
`endif
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle result selection from the latched operands.
    always_comb begin
        ex_res = 8'd0;
        ex_aux = 8'd0;
        ex_err = 1'b0;
        case (op_q)
            OP_ADD: ex_res = a_q + b_q;
            OP_SUB: ex_res = a_q + (~b_q + 8'd1);
            OP_MUL: ex_res = prod[7:0];
            // Sign of the wrapped difference, not a magnitude compare.
            OP_CMP: begin
                if (diff == 8'd0)  ex_res = 8'd0;
                else if (diff[7])  ex_res = 8'd1;
                else               ex_res = 8'd2;
            end
`ifdef ALU_CTRL_DIV_EN
            // Only reached here with a zero divisor.
            OP_DIV: begin
                ex_res = 8'hFF;
                ex_aux = a_q;
                ex_err = 1'b1;
            end
`endif
            default: ex_err = 1'b1;
        endcase
    end

`ifdef ALU_CTRL_DIV_EN
    // One restoring-division step: trial subtract, keep or restore.
    always_comb begin
        trial = {rem_q, quo_q[7]} - {1'b0, b_q};
        if (!trial[8]) begin
            rem_d = trial[7:0];
            quo_d = {quo_q[6:0], 1'b1};
        end else begin
            rem_d = {rem_q[6:0], quo_q[7]};
            quo_d = {quo_q[6:0], 1'b0};
        end
    end
`endif

    // Operand latch, result registers and divider state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            op_q   <= 3'd0;
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            res_q  <= 8'd0;
            aux_q  <= 8'd0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
            rem_q  <= 8'd0;
            quo_q  <= 8'd0;
            cnt_q  <= 4'd0;
`endif
        end else begin
            if (accept) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
            end
            if (state_q == S_EXEC) begin
                res_q  <= ex_res;
                aux_q  <= ex_aux;
                err_q  <= ex_err;
                zero_q <= (ex_res == 8'd0);
            end
`ifdef ALU_CTRL_DIV_EN
            // Down-counter from 7; the iteration seen at zero is the last.
            if (div_start) begin
                rem_q <= 8'd0;
                quo_q <= bus.req_a;
                cnt_q <= 4'd7;
            end else if (state_q == S_DIV) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - 4'd1;
                if (div_last) begin
                    res_q  <= quo_d;
                    aux_q  <= rem_d;
                    err_q  <= 1'b0;
                    zero_q <= (quo_d == 8'd0);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed vector table, mid-divide reset,
// and randomized operations against an arithmetic reference model.
module tb_alu_ctrl;
    logic clk  = 1'b0;
    logic clrn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         res;
        int         aux;
        int         zero;
        int         err;
        int         lat;
        int         stall;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each op.
    task automatic model(input int op, input int a, input int b,
                         output int res, output int aux, output int zero,
                         output int err, output int lat);
        int d;
        res = 0; aux = 0; err = 0; lat = 1;
        case (op)
            0: res = (a + b) % 256;
            1: res = (a - b + 256) % 256;
            2: res = (a * b) % 256;
            3: begin
                d = (a - b + 256) % 256;
                res = (d == 0) ? 0 : ((d >= 128) ? 1 : 2);
            end
`ifdef ALU_CTRL_DIV_EN
            4: begin
                if (b == 0) begin
                    res = 255; aux = a; err = 1;
                end else begin
                    res = a / b; aux = a % b; lat = 8;
                end
            end
`endif
            default: err = 1;
        endcase
        zero = (res == 0) ? 1 : 0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input int e_res, input int e_aux, input int e_zero,
                          input int e_err, input int e_lat, input int stall);
        int lat;
        @(negedge clk);
        chk({nm, ".req_ready_idle"}, int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        // Garbage on the request lines while busy must be ignored.
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_op    = 3'($urandom);
        bus.req_a     = 8'($urandom);
        bus.req_b     = 8'($urandom);
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            chk({nm, ".req_ready_busy"}, int'(bus.req_ready), 0);
            if (lat >= 20) begin
                chk({nm, ".timeout"}, lat, e_lat);
                bus.req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            lat++;
        end
        chk({nm, ".latency"}, lat, e_lat);
        chk({nm, ".result"}, int'(bus.rsp_result), e_res);
        chk({nm, ".aux"}, int'(bus.rsp_aux), e_aux);
        chk({nm, ".zero"}, int'(bus.rsp_zero), e_zero);
        chk({nm, ".err"}, int'(bus.rsp_err), e_err);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, ".stall_valid"}, int'(bus.rsp_valid), 1);
            chk({nm, ".stall_result"}, int'(bus.rsp_result), e_res);
            chk({nm, ".stall_aux"}, int'(bus.rsp_aux), e_aux);
            chk({nm, ".stall_flags"}, int'({bus.rsp_zero, bus.rsp_err}), e_zero * 2 + e_err);
        end
        // Request present on the handshake edge must not be taken.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk({nm, ".post_busy"}, int'(bus.busy), 0);
        chk({nm, ".post_valid"}, int'(bus.rsp_valid), 0);
        chk({nm, ".post_ready"}, int'(bus.req_ready), 1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".req_ready"}, int'(bus.req_ready), 1);
        chk({nm, ".rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({nm, ".result"}, int'(bus.rsp_result), 0);
        chk({nm, ".aux"}, int'(bus.rsp_aux), 0);
        chk({nm, ".zero"}, int'(bus.rsp_zero), 0);
        chk({nm, ".err"}, int'(bus.rsp_err), 0);
        chk({nm, ".busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, x, z, e, l, op, a, b;

        vecs.push_back(vec_t'{op:3'd0, a:8'd200, b:8'd100, res:44,  aux:0, zero:0, err:0, lat:1, stall:5});
        vecs.push_back(vec_t'{op:3'd1, a:8'd5,   b:8'd5,   res:0,   aux:0, zero:1, err:0, lat:1, stall:0});
        vecs.push_back(vec_t'{op:3'd2, a:8'd13,  b:8'd11,  res:143, aux:0, zero:0, err:0, lat:1, stall:1});
        vecs.push_back(vec_t'{op:3'd3, a:8'd3,   b:8'd5,   res:1,   aux:0, zero:0, err:0, lat:1, stall:0});
        vecs.push_back(vec_t'{op:3'd3, a:8'd200, b:8'd10,  res:1,   aux:0, zero:0, err:0, lat:1, stall:0});
        vecs.push_back(vec_t'{op:3'd3, a:8'd10,  b:8'd3,   res:2,   aux:0, zero:0, err:0, lat:1, stall:0});
        vecs.push_back(vec_t'{op:3'd3, a:8'd7,   b:8'd7,   res:0,   aux:0, zero:1, err:0, lat:1, stall:0});
        vecs.push_back(vec_t'{op:3'd6, a:8'd1,   b:8'd2,   res:0,   aux:0, zero:1, err:1, lat:1, stall:2});
`ifdef ALU_CTRL_DIV_EN
        vecs.push_back(vec_t'{op:3'd4, a:8'd100, b:8'd7,   res:14,  aux:2, zero:0, err:0, lat:8, stall:3});
        vecs.push_back(vec_t'{op:3'd4, a:8'd255, b:8'd1,   res:255, aux:0, zero:0, err:0, lat:8, stall:0});
        vecs.push_back(vec_t'{op:3'd4, a:8'd0,   b:8'd5,   res:0,   aux:0, zero:1, err:0, lat:8, stall:0});
        vecs.push_back(vec_t'{op:3'd4, a:8'd9,   b:8'd0,   res:255, aux:9, zero:0, err:1, lat:1, stall:1});
`else
        vecs.push_back(vec_t'{op:3'd4, a:8'd100, b:8'd7,   res:0,   aux:0, zero:1, err:1, lat:1, stall:3});
        vecs.push_back(vec_t'{op:3'd4, a:8'd9,   b:8'd0,   res:0,   aux:0, zero:1, err:1, lat:1, stall:0});
`endif

        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 8'd0;
        bus.req_b     = 8'd0;
        bus.rsp_ready = 1'b0;

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        clrn = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].aux, vecs[i].zero, vecs[i].err,
                   vecs[i].lat, vecs[i].stall);

        // Leave a non-zero response behind, then abort a divide mid-flight.
        run_op("pre_abort", 3'd0, 8'd200, 8'd100, 44, 0, 0, 0, 1, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd4;
        bus.req_a     = 8'd100;
        bus.req_b     = 8'd7;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        clrn = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        clrn = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort.no_response", int'(bus.rsp_valid), 0);
        run_op("after_abort", 3'd0, 8'd1, 8'd1, 2, 0, 0, 0, 1, 0);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            model(op, a, b, r, x, z, e, l);
            run_op($sformatf("rnd%0d_op%0d_a%0d_b%0d", n, op, a, b),
                   3'(op), 8'(a), 8'(b), r, x, z, e, l, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
